// File: rtl/srl_fifo_ctrl.sv
// srl_fifo_ctrl: shift-register FIFO whose storage maps onto SRL primitives.
// Define SRL_FIFO_OREG_EN to add a registered output stage (capacity DEPTH+1).
module srl_fifo_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             r,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [AW-1:0]    count
);

    localparam int TW = $clog2(DEPTH);
    localparam logic [AW-1:0] FULL = AW'(DEPTH);

    logic [WIDTH-1:0] srl [DEPTH];
    logic [AW-1:0]    scnt;
    logic [TW-1:0]    tap;
    logic [WIDTH-1:0] head;
    logic             push;
    logic             take;

    assign in_ready = (scnt != FULL);
    assign push     = in_valid & in_ready;
    assign tap      = TW'(scnt - AW'(1));
    // Guard keeps the tap in range for non-power-of-two depths when empty.
    assign head     = (scnt != '0) ? srl[tap] : '0;

    // No reset and a single write path so the bank maps onto SRLs.
    always_ff @(posedge clk) begin
        if (push) begin
            srl[0] <= in_data;
            for (int k = 1; k < DEPTH; k++) begin
                srl[k] <= srl[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r) begin
            scnt <= '0;
        end else if (push && !take) begin
            scnt <= scnt + AW'(1);
        end else if (!push && take) begin
            scnt <= scnt - AW'(1);
        end
    end

`ifdef SRL_FIFO_OREG_EN
    logic [WIDTH-1:0] oreg;
    logic             ovld;

    // An SRL read into the output register retires a word from scnt.
    assign take = (scnt != '0) & (~ovld | out_ready);

    always_ff @(posedge clk) begin
        if (take) begin
            oreg <= head;
        end
    end

    always_ff @(posedge clk) begin
        if (r) begin
            ovld <= 1'b0;
        end else if (take) begin
            ovld <= 1'b1;
        end else if (ovld && out_ready && scnt == '0) begin
            ovld <= 1'b0;
        end
    end

    assign out_valid = ovld;
    assign out_data  = oreg;
    assign count     = scnt + AW'(ovld);
`else
    assign out_valid = (scnt != '0);
    assign out_data  = head;
    assign take      = out_valid & out_ready;
    assign count     = scnt;
`endif

    a_scnt_range: assert property (
        @(posedge clk) disable iff (r) scnt <= FULL
    );

    a_no_overflow: assert property (
        @(posedge clk) disable iff (r) !(push && !take && scnt == FULL)
    );

    a_no_underflow: assert property (
        @(posedge clk) disable iff (r) !(take && !push && scnt == '0)
    );

endmodule

// File: tb/tb_srl_fifo_ctrl.sv
// tb_srl_fifo_ctrl: vector table, corner sequences and random traffic
// checked against a queue model of the FIFO contents.
module tb_srl_fifo_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
`ifdef SRL_FIFO_OREG_EN
    localparam bit OREG = 1'b1;
`else
    localparam bit OREG = 1'b0;
`endif
    localparam int CAP = DEPTH + int'(OREG);

    logic             clk;
    logic             r;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [4:0]       count;

    srl_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .r         (r),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit         r;
        bit         iv;
        logic [7:0] d;
        bit         ordy;
        bit         irdy;
        bit         ov;
        int         cnt;
        logic [7:0] data;
    } vec_t;

    int         total = 0;
    int         bad = 0;
    logic [7:0] sb[$];
    logic [7:0] got[$];
    bit         ovld_m = 1'b0;
    logic       s_irdy;
    logic       s_ov;
    logic [4:0] s_cnt;
    logic [7:0] s_data;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle, check outputs at the falling edge, advance the model.
    task automatic cycle(input bit rr, input bit iv, input logic [7:0] d,
                         input bit ordy);
        int sc;
        bit irdy_m;
        bit ov_m;
        bit push;
        bit pop;
        bit load;
        r = rr;
        in_valid = iv;
        in_data = d;
        out_ready = ordy;
        @(negedge clk);
        s_irdy = in_ready;
        s_ov = out_valid;
        s_cnt = count;
        s_data = out_data;
        sc = sb.size() - int'(ovld_m);
        irdy_m = (sc != DEPTH);
        ov_m = OREG ? ovld_m : (sb.size() != 0);
        chk("in_ready", in_ready, irdy_m);
        chk("out_valid", out_valid, ov_m);
        chk("count", count, sb.size());
        chk("ready_or_valid", in_ready | out_valid, 1);
        if (ov_m) chk("out_data", out_data, sb[0]);
        if (!rr && out_valid && ordy) got.push_back(out_data);
        if (rr) begin
            sb.delete();
            ovld_m = 1'b0;
        end else begin
            push = iv && irdy_m;
            pop = ov_m && ordy;
            load = OREG && sc != 0 && (!ovld_m || ordy);
            if (pop) void'(sb.pop_front());
            if (push) sb.push_back(d);
            if (OREG) begin
                if (load) ovld_m = 1'b1;
                else if (ordy) ovld_m = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    vec_t       tbl[8];
    int         aa_idx;
    logic [7:0] e;

    initial begin
        tbl[0] = '{1, 1, 8'hEE, 0, 1, 0, 0, 8'h00};
        tbl[1] = '{1, 1, 8'hEE, 0, 1, 0, 0, 8'h00};
        tbl[2] = '{0, 0, 8'h00, 0, 1, 0, 0, 8'h00};
        tbl[3] = '{0, 1, 8'h11, 0, 1, 0, 0, 8'h00};
        tbl[4] = '{0, 1, 8'h22, 0, 1, !OREG, 1, 8'h11};
        tbl[5] = '{0, 1, 8'h33, 0, 1, 1, 2, 8'h11};
        tbl[6] = '{0, 0, 8'h00, 0, 1, 1, 3, 8'h11};
        tbl[7] = '{0, 0, 8'h00, 0, 1, 1, 3, 8'h11};

        r = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            cycle(tbl[i].r, tbl[i].iv, tbl[i].d, tbl[i].ordy);
            chk($sformatf("tbl%0d_irdy", i), s_irdy, tbl[i].irdy);
            chk($sformatf("tbl%0d_ov", i), s_ov, tbl[i].ov);
            chk($sformatf("tbl%0d_cnt", i), s_cnt, tbl[i].cnt);
            if (tbl[i].ov) chk($sformatf("tbl%0d_data", i), s_data, tbl[i].data);
        end

        // Fill, then offer 0xAA while draining: full+pop takes no push.
        cycle(1, 0, 8'h00, 0);
        for (int i = 0; i < CAP; i++) cycle(0, 1, 8'(i), 0);
        chk("full_count", count, CAP);
        got.delete();
        aa_idx = -1;
        for (int k = 0; k < CAP + 4; k++) begin
            cycle(0, aa_idx < 0, 8'hAA, 1);
            if (aa_idx < 0 && s_irdy) aa_idx = k;
            if (k == 0) chk("full_in_ready", s_irdy, 0);
        end
        chk("aa_push_cycle", aa_idx, 1);
        chk("drain_len", got.size(), CAP + 1);
        for (int j = 0; j < got.size() && j <= CAP; j++) begin
            e = (j < CAP) ? 8'(j) : 8'hAA;
            chk($sformatf("drain%0d", j), got[j], e);
        end

        // Steady push+pop at occupancy 5.
        cycle(1, 0, 8'h00, 0);
        for (int i = 0; i < 5; i++) cycle(0, 1, 8'(8'h40 + i), 0);
        got.delete();
        for (int k = 0; k < 20; k++) begin
            cycle(0, 1, 8'(8'h50 + k), 1);
            chk("steady_count", count, 5);
            chk("steady_valid", s_ov, 1);
        end
        chk("steady_len", got.size(), 20);
        for (int j = 0; j < got.size() && j < 20; j++) begin
            e = (j < 5) ? 8'(8'h40 + j) : 8'(8'h50 + j - 5);
            chk($sformatf("steady%0d", j), got[j], e);
        end

        // Reset mid-operation with traffic on both sides.
        cycle(1, 0, 8'h00, 0);
        for (int i = 0; i < 7; i++) cycle(0, 1, 8'(8'h70 + i), 0);
        chk("pre_rst_count", count, 7);
        cycle(1, 1, 8'h77, 1);
        chk("rst_count", count, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        got.delete();
        cycle(0, 1, 8'h5A, 0);
        for (int k = 0; k < 4; k++) cycle(0, 0, 8'h00, 1);
        chk("rst_pop_len", got.size(), 1);
        chk("rst_first", got.size() > 0 ? got[0] : 8'h00, 8'h5A);

        // Random traffic against the model.
        for (int i = 0; i < 12 * DEPTH; i++) begin
            cycle($urandom_range(0, 19) == 0, 1'($urandom),
                  8'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
